// File: rtl/dsp_cascade_drain.sv
// Output drain for a cascaded DSP chain: round, saturate, FIFO, credit flow control.
// Define DSP_DRAIN_CONVERGENT_EN for round-half-to-even instead of round-half-up.
module dsp_cascade_drain #(
   parameter int OUT_W      = 16,
   parameter int SHIFT      = 15,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [47:0]      p,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   input  logic                    sat_clr,
   output logic                    sat_sticky
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 2;
   localparam logic signed [48:0] MAXV = (49'sd1 <<< (OUT_W-1)) - 49'sd1;
   localparam logic signed [48:0] MINV = -(49'sd1 <<< (OUT_W-1));

   logic                    acc;
   logic                    tap;
   logic                    wr;
   logic                    rd;
   logic [LAT-1:0]          dl;
   logic [LAT:0]            dl_n;
   logic signed [48:0]      pe;
   logic signed [48:0]      rnd;
   logic signed [48:0]      r_val;
   logic                    r_vld;
   logic signed [OUT_W-1:0] s_val;
   logic                    s_sat;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_n;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW-1:0]           rd_ptr_n;
   logic signed [OUT_W-1:0] mem [FIFO_DEPTH];

   // Every beat in flight already owns a FIFO slot, so a write never finds it full.
   assign in_ready = rst_n && ((inflight + cnt) < CW'(FIFO_DEPTH));
   assign acc      = in_valid && in_ready;
   assign dl_n     = {dl, acc};
   assign tap      = dl[LAT-1];
   assign pe       = {p[47], p};
   assign wr       = r_vld;
   assign rd       = out_valid && out_ready;
   assign cnt_n    = cnt + CW'(wr) - CW'(rd);
   assign rd_ptr_n = rd_ptr + AW'(rd);

   if (SHIFT == 0) begin : g_pass
      assign rnd = pe;
   end else begin : g_rnd
      localparam logic signed [48:0] HALF = 49'sd1 <<< (SHIFT-1);
      logic signed [48:0] up;
      assign up = (pe + HALF) >>> SHIFT;
`ifdef DSP_DRAIN_CONVERGENT_EN
      logic signed [48:0] fl;
      logic               tie;
      assign fl  = pe >>> SHIFT;
      assign tie = pe[SHIFT-1:0] == HALF[SHIFT-1:0];
      assign rnd = tie ? fl + 49'(fl[0]) : up;
`else
      assign rnd = up;
`endif
   end

   always_comb begin
      s_sat = 1'b0;
      s_val = r_val[OUT_W-1:0];
      if (r_val > MAXV) begin
         s_val = MAXV[OUT_W-1:0];
         s_sat = 1'b1;
      end else if (r_val < MINV) begin
         s_val = MINV[OUT_W-1:0];
         s_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl         <= '0;
         r_vld      <= 1'b0;
         r_val      <= '0;
         inflight   <= '0;
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         sat_stick_reset: sat_sticky <= 1'b0;
      end else begin
         dl       <= dl_n[LAT-1:0];
         r_vld    <= tap;
         if (tap) r_val <= rnd;
         inflight <= inflight + CW'(acc) - CW'(wr);
         cnt      <= cnt_n;
         rd_ptr   <= rd_ptr_n;
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         out_valid <= cnt_n != '0;
         // Head register: the incoming word when the FIFO drains to it, else the next stored entry.
         if (cnt_n != '0)
            out_data <= (cnt == CW'(rd)) ? s_val : mem[rd_ptr_n];
         if (wr && s_sat)
            sat_sticky <= 1'b1;
         else if (sat_clr)
            sat_sticky <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= s_val;
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n) wr |-> (cnt < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_dsp_cascade_drain.sv
// Bench for dsp_cascade_drain: directed and random beats against a queue-based reference.
// The DSP chain is modelled as a LAT-deep pipe of p values.
module tb_dsp_cascade_drain;

   localparam int OUT_W = 16;
   localparam int SHIFT = 15;
   localparam int LAT   = 3;
   localparam int DEPTH = 8;

   typedef struct {
      longint t;
      longint v;
      bit     s;
   } ent_t;

   logic                    clk       = 1'b0;
   logic                    rst_n     = 1'b0;
   logic                    in_valid  = 1'b0;
   logic                    out_ready = 1'b0;
   logic                    sat_clr   = 1'b0;
   logic signed [47:0]      in_p      = '0;
   logic signed [47:0]      p;
   logic                    in_ready;
   logic                    out_valid;
   logic                    sat_sticky;
   logic signed [OUT_W-1:0] out_data;

   int     compared   = 0;
   int     mismatched = 0;
   int     cyc        = 0;
   int     nacc;
   ent_t   q[$];
   longint rx[$];
   bit     sticky_m   = 1'b0;
   logic signed [47:0] dq [LAT];

   always #5 clk = ~clk;

   // Beats travel the DSP chain; idle slots carry garbage the DUT must ignore.
   always @(posedge clk) begin
      dq[0] <= (in_valid && in_ready) ? in_p : {16'($urandom), $urandom};
      for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
   end
   assign p = dq[LAT-1];

   dsp_cascade_drain #(
      .OUT_W(OUT_W), .SHIFT(SHIFT), .LAT(LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p(p), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .sat_clr(sat_clr), .sat_sticky(sat_sticky)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: floor quotient plus remainder decides rounding, then clamp.
   function automatic longint ref_val(input longint pv, output bit sat);
      longint d;
      longint h;
      longint qq;
      longint r;
      longint mx;
      longint mn;
      d  = longint'(1) << SHIFT;
      qq = pv / d;
      if ((pv % d) != 0 && pv < 0) qq--;
      r  = pv - qq * d;
      if (SHIFT > 0) begin
         h = d / 2;
         if (r > h) qq++;
         else if (r == h) begin
`ifdef DSP_DRAIN_CONVERGENT_EN
            qq += qq & 1;
`else
            qq++;
`endif
         end
      end
      mx  = (longint'(1) << (OUT_W-1)) - 1;
      mn  = -(longint'(1) << (OUT_W-1));
      sat = 1'b0;
      if (qq > mx) begin qq = mx; sat = 1'b1; end
      if (qq < mn) begin qq = mn; sat = 1'b1; end
      return qq;
   endfunction

   function automatic logic signed [47:0] rand_p();
      logic signed [47:0] x;
      case ($urandom_range(0, 3))
         0: x = {16'($urandom), $urandom};
         1: x = 48'($signed($urandom)) >>> 8;
         2: x = 48'($signed($urandom));
         default: x = ((48'($signed($urandom)) >>> 12) <<< SHIFT)
                      + (48'sd1 <<< (SHIFT-1));
      endcase
      return x;
   endfunction

   // One clock cycle: drive, check against the model, advance the model.
   task automatic step(input bit iv, input logic signed [47:0] pv,
                       input bit ordy, input bit clr);
      bit     ev;
      bit     er;
      bit     rd;
      bit     ns;
      bit     sat;
      longint v;
      ent_t   e;
      @(negedge clk);
      in_valid  = iv;
      in_p      = pv;
      out_ready = ordy;
      sat_clr   = clr;
      #1;
      ev = q.size() > 0 && q[0].t <= longint'(cyc);
      er = q.size() < DEPTH;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("sat_sticky", 64'(sat_sticky), 64'(sticky_m));
      if (ev) chk("out_data", 64'(out_data), q[0].v);
      rd = ev && ordy;
      ns = clr ? 1'b0 : sticky_m;
      foreach (q[i]) if (q[i].t == longint'(cyc + 1) && q[i].s) ns = 1'b1;
      sticky_m = ns;
      if (rd) begin
         rx.push_back(longint'(out_data));
         e = q.pop_front();
      end
      if (iv && er) begin
         v = ref_val(longint'(pv), sat);
         q.push_back('{longint'(cyc + LAT + 2), v, sat});
      end
      cyc++;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, rand_p(), ordy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic signed [47:0] rp[4];
      longint             er[4];
      longint             es[3];
      rp = '{48'sd16384, 48'sd49152, -48'sd16384, 48'sd81920};
`ifdef DSP_DRAIN_CONVERGENT_EN
      er = '{0, 2, 0, 2};
`else
      er = '{1, 2, 0, 3};
`endif
      es = '{32767, -32768, 32767};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_sat_sticky", 64'(sat_sticky), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'(1));

      rx.delete();
      for (int i = 0; i < 4; i++) step(1'b1, rp[i], 1'b1, 1'b0);
      idle(LAT + 4, 1'b1);
      chk("round_count", 64'(rx.size()), 64'(4));
      for (int i = 0; i < 4 && i < rx.size(); i++) chk("round_val", rx[i], er[i]);

      rx.delete();
      step(1'b1, 48'sd1 <<< 31, 1'b1, 1'b0);
      step(1'b1, -(48'sd1 <<< 31), 1'b1, 1'b0);
      step(1'b1, 48'sd1 <<< 30, 1'b1, 1'b0);
      idle(LAT + 4, 1'b1);
      chk("sat_count", 64'(rx.size()), 64'(3));
      for (int i = 0; i < 3 && i < rx.size(); i++) chk("sat_val", rx[i], es[i]);
      chk("sat_sticky_held", 64'(sat_sticky), 64'(1));
      step(1'b0, '0, 1'b1, 1'b1);
      idle(1, 1'b1);
      chk("sat_cleared", 64'(sat_sticky), 64'(0));

      step(1'b1, 48'sd1 <<< 40, 1'b1, 1'b0);
      idle(LAT, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      idle(1, 1'b1);
      chk("set_wins", 64'(sat_sticky), 64'(1));
      step(1'b0, '0, 1'b1, 1'b1);
      idle(2, 1'b1);

      rx.delete();
      nacc = 0;
      for (int i = 0; i < 14; i++) begin
         step(1'b1, rand_p(), 1'b0, 1'b0);
         if (in_ready) nacc++;
      end
      chk("bp_accepted", 64'(nacc), 64'(8));
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      idle(10, 1'b1);
      chk("bp_drained", 64'(rx.size()), 64'(8));
      chk("bp_in_ready_back", 64'(in_ready), 64'(1));

      rx.delete();
      for (int k = 0; k < 100; k++) step(1'b1, 48'(k) <<< 15, 1'b1, 1'b0);
      idle(LAT + 4, 1'b1);
      chk("stream_count", 64'(rx.size()), 64'(100));
      for (int k = 0; k < 100 && k < rx.size(); k++) chk("stream_val", rx[k], longint'(k));

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), rand_p(), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0));
      idle(DEPTH + LAT + 4, 1'b1);

      for (int i = 0; i < 5; i++) step(1'b1, rand_p(), 1'b0, 1'b0);
      idle(1, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_out_data", 64'(out_data), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      chk("midrst_sat_sticky", 64'(sat_sticky), 64'(0));
      q.delete();
      sticky_m = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_release_in_ready", 64'(in_ready), 64'(1));
      rx.delete();
      idle(12, 1'b1);
      chk("midrst_no_stale", 64'(rx.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
